// File: rtl/if_id_skid_reg_pkg.sv
// Shared widths, reset constants and occupancy encodings for the fetch->decode
// skid register.
package if_id_skid_reg_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] ZERO     = '0;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-side and decode-side handshake bundle. The slave view belongs to the
// pipeline register; the master view belongs to whoever drives it.
interface if_id_skid_reg_if;
    import if_id_skid_reg_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic [ILEN-1:0] out_inst;
    logic [1:0]      occupancy;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_pc_plus4, out_inst, occupancy
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_plus4, out_inst, occupancy
    );

endinterface

// File: rtl/if_id_skid_reg_pipe_slot.sv
// One pipeline entry: valid bit plus pc, pc+4 and instruction. Load wins over
// drop; drop only clears valid so the data bits stay put.
module if_id_skid_reg_pipe_slot
    import if_id_skid_reg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            drop,
    input  logic [XLEN-1:0] d_pc,
    input  logic [ILEN-1:0] d_inst,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [ILEN-1:0] inst
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid    <= 1'b0;
            pc       <= ZERO;
            pc_plus4 <= ZERO + XLEN'(4);
            inst     <= NOP_INST;
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= d_pc;
            pc_plus4 <= d_pc + XLEN'(4);
            inst     <= d_inst;
        end else if (drop) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// Fetch->decode pipeline register with a one-entry skid buffer so that in_ready
// comes straight from a flop and never depends on out_ready.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    if_id_skid_reg_if.slave         bus
);

    occ_state_t      state;
    logic            in_ready;
    logic            accept;
    logic            consume;

    logic            main_valid;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] main_pc_plus4;
    logic [ILEN-1:0] main_inst;
    logic            main_load;
    logic            main_drop;
    logic            main_from_skid;
    logic [XLEN-1:0] main_d_pc;
    logic [ILEN-1:0] main_d_inst;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc_plus4;
    logic [ILEN-1:0] skid_inst;
    logic            skid_load;
    logic            skid_drop;

    assign accept  = bus.in_valid && in_ready;
    assign consume = main_valid && bus.out_ready;

    // in_ready is written alongside the state so it always equals (next state != FULL)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= OCC_EMPTY;
            in_ready <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) state <= OCC_ONE;
                end
                OCC_ONE: begin
                    if (accept && !consume) begin
                        state    <= OCC_FULL;
                        in_ready <= 1'b0;
                    end else if (!accept && consume) begin
                        state    <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (consume) begin
                        state    <= OCC_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= OCC_EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_drop      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        case (state)
            OCC_EMPTY: main_load = accept;
            OCC_ONE: begin
                if (accept && consume) main_load = 1'b1;
                else if (accept)       skid_load = 1'b1;
                else if (consume)      main_drop = 1'b1;
            end
            OCC_FULL: begin
                if (consume) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_drop      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign main_d_pc   = main_from_skid ? skid_pc   : bus.in_pc;
    assign main_d_inst = main_from_skid ? skid_inst : bus.in_inst;

    if_id_skid_reg_pipe_slot u_main (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (main_load),
        .drop     (main_drop),
        .d_pc     (main_d_pc),
        .d_inst   (main_d_inst),
        .valid    (main_valid),
        .pc       (main_pc),
        .pc_plus4 (main_pc_plus4),
        .inst     (main_inst)
    );

    // The skid's own pc+4 is recomputed when it moves into main, so it is left unused here
    if_id_skid_reg_pipe_slot u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (skid_load),
        .drop     (skid_drop),
        .d_pc     (bus.in_pc),
        .d_inst   (bus.in_inst),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .pc_plus4 (skid_pc_plus4),
        .inst     (skid_inst)
    );

    logic unused_skid;
    assign unused_skid = skid_valid ^ (^skid_pc_plus4);

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = main_valid;
    assign bus.out_pc       = main_pc;
    assign bus.out_pc_plus4 = main_pc_plus4;
    assign bus.out_inst     = main_inst;
    assign bus.occupancy    = state;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for the fetch->decode skid register: reset, streaming, stall,
// flush, pc+4 wrap and reset-over-flush scenarios.
module tb_if_id_skid_reg;
    import if_id_skid_reg_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   vectors;
    int   miscompares;

    if_id_skid_reg_if bus ();

    if_id_skid_reg dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h0000_0100; bus.in_inst = 32'h1111_1111;
        bus.out_ready = 1'b0;
        tick(); tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL reset occupancy: got %0d want 0", bus.occupancy); end
        vectors++; if (bus.out_inst !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL reset out_inst: got %h want 00000013", bus.out_inst); end
        vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset out_pc: got %h want 00000000", bus.out_pc); end
        vectors++; if (bus.out_pc_plus4 !== 32'h4) begin miscompares++; $display("[TB] FAIL reset out_pc_plus4: got %h want 00000004", bus.out_pc_plus4); end
        rst = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] pcs   [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] insts [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        logic [31:0] plus4 [3] = '{32'h4, 32'h8, 32'hC};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_pc = pcs[i]; bus.in_inst = insts[i];
            tick();
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stream[%0d] out_valid: got %b want 1", i, bus.out_valid); end
            vectors++; if (bus.out_pc !== pcs[i]) begin miscompares++; $display("[TB] FAIL stream[%0d] out_pc: got %h want %h", i, bus.out_pc, pcs[i]); end
            vectors++; if (bus.out_pc_plus4 !== plus4[i]) begin miscompares++; $display("[TB] FAIL stream[%0d] out_pc_plus4: got %h want %h", i, bus.out_pc_plus4, plus4[i]); end
            vectors++; if (bus.out_inst !== insts[i]) begin miscompares++; $display("[TB] FAIL stream[%0d] out_inst: got %h want %h", i, bus.out_inst, insts[i]); end
            vectors++; if (bus.occupancy !== 2'd1) begin miscompares++; $display("[TB] FAIL stream[%0d] occupancy: got %0d want 1", i, bus.occupancy); end
            vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream[%0d] in_ready: got %b want 1", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream drain out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL stream drain occupancy: got %0d want 0", bus.occupancy); end
        vectors++; if (bus.out_pc !== 32'h8) begin miscompares++; $display("[TB] FAIL stream drain held out_pc: got %h want 00000008", bus.out_pc); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h10; bus.in_inst = 32'h0040_0213;
        tick();
        vectors++; if (bus.out_pc !== 32'h10) begin miscompares++; $display("[TB] FAIL stall first out_pc: got %h want 00000010", bus.out_pc); end
        bus.in_pc = 32'h14; bus.in_inst = 32'h0050_0293;
        tick();
        vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL stall full occupancy: got %0d want 2", bus.occupancy); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall full in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.out_pc !== 32'h10) begin miscompares++; $display("[TB] FAIL stall full out_pc: got %h want 00000010", bus.out_pc); end
        // fetch keeps offering while full; nothing must enter
        bus.in_pc = 32'h99; bus.in_inst = 32'hDEAD_BEEF;
        tick();
        vectors++; if (bus.out_pc !== 32'h10 || bus.out_inst !== 32'h0040_0213) begin miscompares++; $display("[TB] FAIL stall hold out_pc/inst: got %h/%h want 00000010/00400213", bus.out_pc, bus.out_inst); end
        vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL stall hold occupancy: got %0d want 2", bus.occupancy); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        vectors++; if (bus.out_pc !== 32'h14) begin miscompares++; $display("[TB] FAIL stall release out_pc: got %h want 00000014", bus.out_pc); end
        vectors++; if (bus.out_pc_plus4 !== 32'h18) begin miscompares++; $display("[TB] FAIL stall release out_pc_plus4: got %h want 00000018", bus.out_pc_plus4); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stall release in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.occupancy !== 2'd1) begin miscompares++; $display("[TB] FAIL stall release occupancy: got %0d want 1", bus.occupancy); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall drain out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h30; bus.in_inst = 32'h0060_0313;
        tick();
        bus.in_pc = 32'h34; bus.in_inst = 32'h0070_0393;
        tick();
        vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL flush setup occupancy: got %0d want 2", bus.occupancy); end
        flush = 1'b1; bus.in_pc = 32'h20; bus.in_inst = 32'h0080_0413;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush full out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL flush full occupancy: got %0d want 0", bus.occupancy); end
        vectors++; if (bus.out_inst !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL flush full out_inst: got %h want 00000013", bus.out_inst); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush full in_ready: got %b want 1", bus.in_ready); end
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (bus.out_valid !== 1'b0 || bus.out_pc === 32'h20) begin miscompares++; $display("[TB] FAIL flush after[%0d] out_valid/out_pc: got %b/%h want 0/not 00000020", i, bus.out_valid, bus.out_pc); end
        end
        // flush from ONE while fetch offers a same-cycle accept
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_pc = 32'h40; bus.in_inst = 32'h0090_0493;
        tick();
        flush = 1'b1; bus.in_pc = 32'h44;
        tick();
        vectors++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL flush one valid/occ: got %b/%0d want 0/0", bus.out_valid, bus.occupancy); end
        flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush one after out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_pc = 32'hFFFF_FFFC; bus.in_inst = 32'h00A0_0513;
        tick();
        vectors++; if (bus.out_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap out_pc: got %h want fffffffc", bus.out_pc); end
        vectors++; if (bus.out_pc_plus4 !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap out_pc_plus4: got %h want 00000000", bus.out_pc_plus4); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_over_flush();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_pc = 32'h50; bus.in_inst = 32'h00B0_0593;
        tick();
        bus.in_pc = 32'h54; bus.in_inst = 32'h00C0_0613;
        tick();
        vectors++; if (bus.occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL rstflush setup occupancy: got %0d want 2", bus.occupancy); end
        rst = 1'b1; flush = 1'b1; bus.in_pc = 32'h58; bus.out_ready = 1'b1;
        tick();
        vectors++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstflush valid/occ/ready: got %b/%0d/%b want 0/0/1", bus.out_valid, bus.occupancy, bus.in_ready); end
        vectors++; if (bus.out_pc !== 32'h0 || bus.out_pc_plus4 !== 32'h4 || bus.out_inst !== 32'h13) begin miscompares++; $display("[TB] FAIL rstflush data: got %h/%h/%h want 00000000/00000004/00000013", bus.out_pc, bus.out_pc_plus4, bus.out_inst); end
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL rstflush after valid/occ: got %b/%0d want 0/0", bus.out_valid, bus.occupancy); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_over_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
